// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and status-register layout
// shared by the spi_flash_target responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    localparam int unsigned STAT_WIP_BIT = 0;
    localparam int unsigned STAT_WEL_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_STATUS,
        ST_ID,
        ST_IGNORE
    } state_e;

    // Status register image; WIP is never set because writes complete instantly.
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s               = '0;
        s[STAT_WEL_BIT] = wel;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_target_sync.sv
// spi_sync_edge: 2-flop synchronizer for one asynchronous pin plus a third
// flop for rise/fall strobes. All flops reset low so no false edge is seen
// after reset; a falling edge therefore always requires a real high first.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values of the synchronizer chain
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-detect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_target.sv
// spi_flash_target: SPI mode-0 responder emulating a small serial NOR flash
// (READ, RDSR, RDID, plus WREN/PP when SPI_TARGET_PROGRAM_EN is defined;
// without that macro the memory is a ROM holding mem[i] = i).
module spi_flash_target #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       cmd_valid,
    output logic [7:0] cmd_code
);
    import spi_flash_pkg::*;

    logic cs_lvl, cs_rise_unused, cs_fall;
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        cmd_code_q, cmd_code_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              miso_q, miso_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        addr_cnt_q, addr_cnt_d;
    logic [1:0]        id_cnt_q, id_cnt_d;
    logic [7:0]        rx_byte;
    logic [7:0]        resp;
    logic              byte_done;
    logic              wel;

`ifdef SPI_TARGET_PROGRAM_EN
    localparam int unsigned DEPTH = 1 << ADDR_W;
    // Page-program increments wrap inside a 256-byte page.
    localparam logic [ADDR_W-1:0] PAGE_MASK =
        (ADDR_W > 8) ? ADDR_W'(8'hFF) : {ADDR_W{1'b1}};

    typedef logic [7:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) m[i] = i[7:0];
        return m;
    endfunction

    mem_t mem = mem_init();
    logic wel_q, wel_d;
    logic wrote_q, wrote_d;
    logic mem_we;
    assign wel = wel_q;
`else
    assign wel = 1'b0;
`endif

    spi_sync_edge u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .level(cs_lvl), .rise(cs_rise_unused), .fall(cs_fall)
    );
    spi_sync_edge u_sync_sck (
        .clk(clk), .rst(rst), .din(sck),
        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign rx_byte   = {rx_q, mosi_lvl};
    assign byte_done = sck_rise & ~cs_lvl & (bit_cnt_q == 3'd7);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: frame start, command decode, end of address phase
    always_comb begin
        state_d = state_q;
        if (cs_lvl) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            CMD_READ: state_d = ST_ADDR;
`ifdef SPI_TARGET_PROGRAM_EN
                            CMD_PP:   state_d = ST_ADDR;
`endif
                            CMD_RDSR: state_d = ST_STATUS;
                            CMD_RDID: state_d = ST_ID;
                            default:  state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (byte_done && addr_cnt_q == 2'd2) begin
`ifdef SPI_TARGET_PROGRAM_EN
                        state_d = (cmd_code_q == CMD_PP) ? ST_WR_DATA : ST_RD_DATA;
`else
                        state_d = ST_RD_DATA;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM output: the byte to present at the next byte boundary
    always_comb begin
        resp = '0;
        case (state_q)
            ST_RD_DATA: resp = rd_data_q;
            ST_STATUS:  resp = status_byte(wel);
            ST_ID: begin
                case (id_cnt_q)
                    2'd0:    resp = JEDEC_ID[23:16];
                    2'd1:    resp = JEDEC_ID[15:8];
                    2'd2:    resp = JEDEC_ID[7:0];
                    default: resp = '0;
                endcase
            end
            default: resp = '0;
        endcase
    end

    // Datapath: bit/byte assembly, MISO shifting, address and WEL tracking.
    // A response byte is loaded on the first falling edge of a byte so the
    // registered memory read has several clocks to settle after addr changes.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        addr_d      = addr_q;
        addr_cnt_d  = addr_cnt_q;
        id_cnt_d    = id_cnt_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
`ifdef SPI_TARGET_PROGRAM_EN
        rd_data_d   = mem[addr_q];
        wel_d       = wel_q;
        wrote_d     = wrote_q;
        mem_we      = 1'b0;
`else
        rd_data_d   = 8'(addr_q);
`endif
        if (cs_lvl) begin
            bit_cnt_d  = '0;
            tx_d       = '0;
            miso_d     = 1'b0;
            addr_cnt_d = '0;
            id_cnt_d   = '0;
`ifdef SPI_TARGET_PROGRAM_EN
            if (wrote_q) wel_d = 1'b0;
            wrote_d = 1'b0;
`endif
        end else begin
            if (sck_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (sck_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    miso_d = resp[7];
                    tx_d   = {resp[6:0], 1'b0};
                    if (state_q == ST_RD_DATA) addr_d = addr_q + ADDR_W'(1);
                    if (state_q == ST_ID && id_cnt_q != 2'd3) id_cnt_d = id_cnt_q + 2'd1;
                end else begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            if (byte_done) begin
                case (state_q)
                    ST_CMD: begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = rx_byte;
`ifdef SPI_TARGET_PROGRAM_EN
                        if (rx_byte == CMD_WREN) wel_d = 1'b1;
`endif
                    end
                    ST_ADDR: begin
                        addr_d     = ADDR_W'({addr_q, rx_byte});
                        addr_cnt_d = addr_cnt_q + 2'd1;
                    end
`ifdef SPI_TARGET_PROGRAM_EN
                    ST_WR_DATA: begin
                        if (wel_q) begin
                            mem_we  = 1'b1;
                            wrote_d = 1'b1;
                        end
                        addr_d = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_W'(1)) & PAGE_MASK);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            addr_cnt_q  <= '0;
            id_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            rd_data_q   <= '0;
`ifdef SPI_TARGET_PROGRAM_EN
            wel_q       <= 1'b0;
            wrote_q     <= 1'b0;
`endif
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            addr_cnt_q  <= addr_cnt_d;
            id_cnt_q    <= id_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            rd_data_q   <= rd_data_d;
`ifdef SPI_TARGET_PROGRAM_EN
            wel_q       <= wel_d;
            wrote_q     <= wrote_d;
`endif
        end
    end

`ifdef SPI_TARGET_PROGRAM_EN
    // Memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= rx_byte;
    end
`endif

    assign miso      = miso_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// tb_spi_flash_target: drives SPI frames at the pins, keeps a byte-level flash
// model, and checks MISO bytes and cmd_valid/cmd_code through scoreboards.
module tb_spi_flash_target;

    localparam int unsigned HALF = 6;
`ifdef SPI_TARGET_PROGRAM_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       cmd_valid;
    logic [7:0] cmd_code;

    typedef struct packed {
        bit         chk;
        logic [7:0] exp;
    } sb_t;

    sb_t        sb_q [$];
    logic [7:0] cmd_q [$];
    logic [7:0] wdat [$];
    logic [7:0] model_mem [256];
    bit         model_wel = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    spi_flash_target #(.ADDR_W(8), .JEDEC_ID(24'hEF4016)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .cmd_valid(cmd_valid), .cmd_code(cmd_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input bit chk, input logic [7:0] exp);
        sb_q.push_back('{chk: chk, exp: exp});
    endtask

    task automatic xfer(input logic [7:0] b, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // One frame: command, optional 3 address bytes, n data bytes, optional partial byte
    task automatic frame(input logic [7:0] cmd, input logic [23:0] addr,
                         input int unsigned n, input int unsigned tail_bits);
        logic [7:0] a8, d, e;
        bit has_addr, is_mem, wrote;
        has_addr = (cmd == 8'h03) || (cmd == 8'h02);
        is_mem   = (cmd == 8'h03) || (PROG && cmd == 8'h02);
        wrote    = 1'b0;
        a8       = addr[7:0];
        cs_low();
        cmd_q.push_back(cmd);
        push(1'b0, 8'h00);
        xfer(cmd, 8);
        if (PROG && cmd == 8'h06) model_wel = 1'b1;
        if (has_addr) begin
            for (int k = 0; k < 3; k++) begin
                push(!is_mem, 8'h00);
                xfer(addr[23-8*k -: 8], 8);
            end
        end
        for (int unsigned k = 0; k < n; k++) begin
            if (is_mem && cmd == 8'h03) begin
                push(1'b1, model_mem[a8]);
                xfer(8'($urandom), 8);
            end else if (is_mem) begin
                d = (wdat.size() != 0) ? wdat.pop_front() : 8'($urandom);
                push(1'b0, 8'h00);
                xfer(d, 8);
                if (model_wel) begin
                    model_mem[a8] = d;
                    wrote = 1'b1;
                end
            end else begin
                case (cmd)
                    8'h05:   e = {6'b0, model_wel, 1'b0};
                    8'h9F:   e = (k == 0) ? 8'hEF : (k == 1) ? 8'h40 : (k == 2) ? 8'h16 : 8'h00;
                    default: e = 8'h00;
                endcase
                push(1'b1, e);
                xfer(8'($urandom), 8);
            end
            a8 = a8 + 8'd1;
        end
        if (tail_bits != 0) xfer(8'($urandom), tail_bits);
        cs_high();
        if (wrote) model_wel = 1'b0;
    endtask

    // MISO monitor: assembles bytes at SCK rising edges and scores them
    initial begin : mon_miso
        logic [7:0] sh;
        int unsigned nb;
        sb_t ent;
        sh = '0;
        nb = 0;
        forever begin
            @(posedge sck or posedge cs);
            if (cs) begin
                nb = 0;
            end else begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (sb_q.size() == 0) begin
                        check("miso_unexpected_byte", 32'(sh), 32'hFFFF_FFFF);
                    end else begin
                        ent = sb_q.pop_front();
                        if (ent.chk) check("miso_byte", 32'(sh), 32'(ent.exp));
                    end
                end
            end
        end
    end

    // Command monitor: every cmd_valid pulse must match one issued command
    initial begin : mon_cmd
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                if (cmd_q.size() == 0) check("cmd_valid_extra", 32'(cmd_code), 32'hFFFF_FFFF);
                else check("cmd_code", 32'(cmd_code), 32'(cmd_q.pop_front()));
            end
        end
    end

    initial begin : main
        int unsigned sel, n;
        logic [7:0] c;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i);

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_cmd_code", 32'(cmd_code), 32'd0);
        repeat (4) @(negedge clk);

        frame(8'h9F, 24'h0, 4, 0);
        frame(8'h03, 24'h0000FE, 4, 0);
        frame(8'h05, 24'h0, 2, 0);
        frame(8'h06, 24'h0, 0, 0);
        frame(8'h05, 24'h0, 1, 0);
        wdat.push_back(8'hA5);
        wdat.push_back(8'h5A);
        frame(8'h02, 24'h000010, 2, 0);
        frame(8'h03, 24'h000010, 2, 0);
        frame(8'h05, 24'h0, 1, 0);
        wdat.push_back(8'h77);
        frame(8'h02, 24'h000020, 1, 0);
        frame(8'h03, 24'h000020, 1, 0);

        // Partial data byte must not write and must not clear WEL
        frame(8'h06, 24'h0, 0, 0);
        frame(8'h02, 24'h000030, 0, 5);
        frame(8'h03, 24'h000030, 1, 0);
        frame(8'h05, 24'h0, 1, 0);

        // Reset in the middle of a read stream
        cs_low();
        cmd_q.push_back(8'h03);
        push(1'b0, 8'h00);
        xfer(8'h03, 8);
        for (int k = 0; k < 3; k++) begin
            push(1'b0, 8'h00);
            xfer((k == 2) ? 8'h40 : 8'h00, 8);
        end
        push(1'b1, model_mem[8'h40]);
        xfer(8'h00, 8);
        push(1'b1, model_mem[8'h41]);
        xfer(8'h00, 8);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_wel = 1'b0;
        repeat (4) @(negedge clk);
        check("miso_after_rst", 32'(miso), 32'd0);
        check("cmd_code_after_rst", 32'(cmd_code), 32'd0);
        push(1'b1, 8'h00);
        xfer(8'hFF, 8);
        push(1'b1, 8'h00);
        xfer(8'hA5, 8);
        cs_high();
        frame(8'h9F, 24'h0, 3, 0);

        // Program attempt that only takes effect when programming is built in
        frame(8'h06, 24'h0, 0, 0);
        wdat.push_back(8'h33);
        frame(8'h02, 24'h000005, 1, 0);
        frame(8'h03, 24'h000005, 1, 0);
        frame(8'h05, 24'h0, 1, 0);

        // Page-wrap write and upper-address-bit masking
        frame(8'h06, 24'h0, 0, 0);
        frame(8'h02, 24'hABCDFF, 2, 0);
        frame(8'h03, 24'h12FFFF, 3, 0);

        for (int r = 0; r < 30; r++) begin
            sel = $urandom_range(0, 6);
            n   = $urandom_range(1, 4);
            case (sel)
                0: frame(8'h03, 24'($urandom), n, 0);
                1: begin
                    frame(8'h06, 24'h0, 0, 0);
                    frame(8'h02, 24'($urandom), n, 0);
                end
                2: frame(8'h02, 24'($urandom), n, 0);
                3: frame(8'h05, 24'h0, n, 0);
                4: frame(8'h9F, 24'h0, n, 0);
                5: frame(8'h06, 24'h0, 0, 0);
                default: begin
                    c = 8'($urandom);
                    frame(c, 24'($urandom), n, 0);
                end
            endcase
        end

        repeat (20) @(negedge clk);
        check("miso_scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("cmd_scoreboard_drained", 32'(cmd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
